alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one alu instance between NREQ requesters via valid/ready request and response channels.
//  Round-robin grant; operands registered, one op in flight, result held until its requester takes it.
//  Sits between issue logic and the alu; no other block drives alu control directly.
// PARAMETERS
//  BITS      8   operand/result width, passed to the alu instance
//  NREQ      2   number of requesters (2..8)
//  MAX_LOCK  4   max consecutive grants under lock (ALU_ARB_LOCK_EN only), >=1
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_ni       in   1          reset, asynchronous, active-low
//  req_valid_i  in   NREQ       request valid, one bit per requester
//  req_ready_o  out  NREQ       request accepted (one-hot or zero)
//  req_a_i      in   NREQ*BITS  operand A, requester k at [k*BITS +: BITS]
//  req_b_i      in   NREQ*BITS  operand B, same packing
//  req_op_i     in   NREQ*3     alu control code, requester k at [k*3 +: 3]
//  rsp_valid_o  out  NREQ       result valid, one-hot, only to the requester that issued
//  rsp_ready_i  in   NREQ       requester accepts result
//  rsp_data_o   out  BITS       result, shared bus, valid with rsp_valid_o
//  rsp_flags_o  out  4          alu flags {c,n,v,o}, registered with rsp_data_o
//  busy_o       out  1          state != IDLE
//  req_lock_i   in   NREQ       keep grant for next op (ALU_ARB_LOCK_EN only)
// BEHAVIOUR
//  Reset: async on rst_ni low; state=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_flags_o=0,
//   busy_o=0, rr pointer=0, lock count=0. Reset mid-op discards in-flight op; no response issued.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if any req_valid_i, pick winner g = first valid at or after rr pointer (wrapping NREQ-1->0);
//   req_ready_o[g]=1 combinationally same cycle; capture a,b,op,g at edge; go EXEC. Else stay.
//  EXEC: alu sees registered a,b,op; result/flags registered at edge; go RESP. req_ready_o=0.
//  RESP: rsp_valid_o[g]=1; data/flags stable until rsp_ready_i[g]; on handshake go IDLE,
//   rr pointer = (g+1) mod NREQ. rsp_ready_i of other requesters ignored.
//  Latency: accept edge T -> rsp_valid_o high from T+2; min issue interval 3 cycles.
//  req_ready_o high only in IDLE and only for a requester with req_valid_i high; never two bits.
//  Requester k may drop req_valid_i before grant; no accept recorded.
//  Same requester requesting in IDLE while its earlier response just retired: legal, arbitrated normally.
//  op codes passed unmodified; arbiter never decodes them.
// CONFIGURATION
//  ALU_ARB_LOCK_EN defined: on response handshake, if req_lock_i[g]=1 and lock count<MAX_LOCK-1,
//   rr pointer stays at g and lock count increments (g wins next IDLE if valid); otherwise
//   pointer advances and count clears. Count clears on any grant to a different requester.
//  Not defined: req_lock_i port absent; pure round-robin.
// STRUCTURE
//  alu_pkg: typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} arb_state_t; alu op code
//   localparams (3-bit); flag index localparams FLAG_O=0, FLAG_V=1, FLAG_N=2, FLAG_C=3.
//  Sub-module rr_picker #(NREQ): combinational valid vector + pointer -> one-hot grant + index.
//  One alu #(BITS) instance fed only from the operand registers.
// TESTING
//  Reset mid-EXEC: rst_ni low 1 cycle -> all outputs 0, no rsp_valid_o ever for that op.
//  Single req k=0, a=8'h0F b=8'hF0 op=OR -> ready_o=01 at T, rsp_valid_o=01 at T+2, data=8'hFF.
//  Both valid every cycle, rsp_ready_i=11 -> grants alternate 0,1,0,1; each served once per 6 cycles.
//  Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> data/flags stable, no new req_ready_o.
//  Pointer=1, only req 0 valid -> req 0 granted (wrap), next pointer=1.
//  LOCK_EN, MAX_LOCK=4, req0 lock=1 and both valid -> grants 0,0,0,0,1,0; without macro 0,1,0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: FSM states,
// 3-bit ALU op codes and the bit positions of the {c,n,v,o} flag vector.
package alu_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} arb_state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASB = 3'd7;

  // o = result is zero, v = signed overflow, n = result msb, c = carry/borrow/shifted-out bit
  localparam int unsigned FLAG_O = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 3;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight 3-bit ops on BITS-wide operands, result plus {c,n,v,o} flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic [2:0]      op_i,
  output logic [BITS-1:0] res_o,
  output logic [3:0]      flags_o
);

  localparam int unsigned M = BITS - 1;

  logic [BITS:0] wide;

  // Compute the extended result (bit BITS is the carry) and derive flags from it
  always_comb begin
    wide    = '0;
    flags_o = '0;
    case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      OP_SHL:  wide = {a_i, 1'b0};
      OP_SHR:  wide = {a_i[0], 1'b0, a_i[M:1]};
      default: wide = {1'b0, b_i};
    endcase
    res_o           = wide[M:0];
    flags_o[FLAG_C] = wide[BITS];
    flags_o[FLAG_N] = wide[M];
    flags_o[FLAG_O] = (wide[M:0] == '0);
    if (op_i == OP_ADD)
      flags_o[FLAG_V] = (a_i[M] == b_i[M]) && (wide[M] != a_i[M]);
    else if (op_i == OP_SUB)
      flags_o[FLAG_V] = (a_i[M] != b_i[M]) && (wide[M] != a_i[M]);
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after the pointer, wrapping.
module rr_picker #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] k;

  // Scan requesters in priority order starting at the pointer; first hit wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = IW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && valid_i[k]) begin
        any_o      = 1'b1;
        idx_o      = k;
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant in IDLE, operands
// registered, one op in flight, result held until the issuing requester takes it.
// Optional build macro ALU_ARB_LOCK_EN adds req_lock_i / MAX_LOCK grant locking.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned NREQ = 2
`ifdef ALU_ARB_LOCK_EN
  , parameter int unsigned MAX_LOCK = 4
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*BITS-1:0] req_a_i,
  input  logic [NREQ*BITS-1:0] req_b_i,
  input  logic [NREQ*3-1:0]    req_op_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [BITS-1:0]      rsp_data_o,
  output logic [3:0]           rsp_flags_o,
  output logic                 busy_o
`ifdef ALU_ARB_LOCK_EN
  , input  logic [NREQ-1:0]    req_lock_i
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [BITS-1:0] a_q, b_q, res_q, alu_res;
  logic [2:0]      op_q;
  logic [3:0]      flags_q, alu_flags;
  logic [IW-1:0]   g_q, ptr_q, ptr_d, ptr_next, pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            pick_any, accept, retire;

`ifdef ALU_ARB_LOCK_EN
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);
  logic [LW-1:0] lock_q, lock_d;
`endif

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  alu #(.BITS(BITS)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  assign ptr_next    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
  assign rsp_data_o  = res_q;
  assign rsp_flags_o = flags_q;
  assign busy_o      = (state_q != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, request/response handshakes
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready_o = pick_grant;
          accept      = 1'b1;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid_o[g_q] = 1'b1;
        if (rsp_ready_i[g_q]) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin pointer update on response retirement (optionally held by lock)
  always_comb begin
    ptr_d = ptr_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d = lock_q;
    // a grant landing anywhere but the held pointer breaks the lock run
    if (accept && (pick_idx != ptr_q)) lock_d = '0;
    if (retire) begin
      if (req_lock_i[g_q] && (32'(lock_q) < MAX_LOCK - 1)) begin
        ptr_d  = g_q;
        lock_d = lock_q + 1'b1;
      end else begin
        ptr_d  = ptr_next;
        lock_d = '0;
      end
    end
`else
    if (retire) ptr_d = ptr_next;
`endif
  end

  // Operand capture at grant, result capture after EXEC, pointer/lock registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      g_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      ptr_q   <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_q  <= '0;
`endif
    end else begin
      if (accept) begin
        a_q  <= req_a_i[pick_idx*BITS +: BITS];
        b_q  <= req_b_i[pick_idx*BITS +: BITS];
        op_q <= req_op_i[pick_idx*3 +: 3];
        g_q  <= pick_idx;
      end
      if (state_q == ST_EXEC) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
      end
      ptr_q <= ptr_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model (latency counted from accept).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned BITS = 8;
  localparam int unsigned NREQ = 2;
`ifdef ALU_ARB_LOCK_EN
  localparam int unsigned MAX_LOCK = 4;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*BITS-1:0] req_a, req_b;
  logic [NREQ*3-1:0]    req_op;
  logic [BITS-1:0]      rsp_data;
  logic [3:0]           rsp_flags;
  logic                 busy;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // model state
  int        m_ptr, m_lock, m_g, m_acc, cyc;
  bit        m_busy;
  logic [11:0] m_exp;

  always #5 clk = ~clk;

  alu_arbiter #(
    .BITS(BITS),
    .NREQ(NREQ)
`ifdef ALU_ARB_LOCK_EN
    , .MAX_LOCK(MAX_LOCK)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_flags_o (rsp_flags),
    .busy_o      (busy)
`ifdef ALU_ARB_LOCK_EN
    , .req_lock_i (req_lock)
`endif
  );

  // Reference ALU from arithmetic definitions: returns {c,n,v,o, result}
  function automatic logic [11:0] ref_alu(int a, int b, int op);
    int r, s, sa, sb;
    bit c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0;
    case (op)
      0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (a >= 128); end
      6: begin r = a / 2; c = (a % 2) == 1; end
      default: r = b;
    endcase
    r = (r + 256) % 256;
    return {c, (r >= 128), v, (r == 0), 8'(r)};
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [NREQ-1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 99;
  endfunction

  task automatic do_reset();
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_lock = 0; m_busy = 0; m_g = 0; m_acc = 0; cyc = 0;
  endtask

  task automatic test_reset();
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rsp_data); end
    n_vec++; if (rsp_flags !== 4'h0) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", rsp_flags); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_or();
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_a = {8'h00, 8'h0F}; req_b = {8'h00, 8'hF0}; req_op = {3'd0, OP_OR};
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL or_ready got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL or_exec got rv=%b busy=%b exp rv=00 busy=1", rsp_valid, busy); end
    @(negedge clk); #1;
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL or_rsp_valid got=%b exp=01", rsp_valid); end
    n_vec++; if (rsp_data !== 8'hFF) begin n_err++; $display("FAIL or_data got=%h exp=ff", rsp_data); end
    n_vec++; if (rsp_flags !== 4'b0100) begin n_err++; $display("FAIL or_flags got=%b exp=0100", rsp_flags); end
    @(negedge clk); #1;
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL or_retire got rv=%b busy=%b exp rv=00 busy=0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int g[$];
    int t[$];
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a = $urandom; req_b = $urandom; req_op = $urandom;
    for (int c = 0; c < 40 && g.size() < 4; c++) begin
      #1;
      if (req_ready !== 2'b00) begin g.push_back(onehot_idx(req_ready)); t.push_back(c); end
      @(negedge clk);
    end
    n_vec++;
    if (g.size() != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", g.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (g[i] != i % 2) begin n_err++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, g[i], i % 2); end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (t[i+1] - t[i] != 3) begin n_err++; $display("FAIL b2b_interval%0d got=%0d exp=3", i, t[i+1] - t[i]); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_a = {8'h00, 8'h80}; req_b = {8'h00, 8'h80}; req_op = {3'd0, OP_ADD};
    @(negedge clk); req_valid = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 2'b01 || rsp_data !== 8'h00 || rsp_flags !== 4'b1011 || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL bp_hold%0d got rv=%b d=%h f=%b rdy=%b exp rv=01 d=00 f=1011 rdy=00", c, rsp_valid, rsp_data, rsp_flags, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    n_vec++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin n_err++; $display("FAIL bp_after got rv=%b rdy=%b exp rv=00 rdy=10", rsp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 2'b01; req_a = $urandom; req_b = $urandom; req_op = $urandom;
    req_valid = 2'b01;
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b01; #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wrap_grant got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11; #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL wrap_ptr got=%b exp=10", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_a = {8'h00, 8'h12}; req_b = {8'h00, 8'h34}; req_op = {3'd0, OP_ADD};
    @(negedge clk);
    req_valid = '0; rst_n = 1'b0; #1;
    n_vec++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rst_hs got rdy=%b rv=%b exp 00 00", req_ready, rsp_valid); end
    n_vec++; if (rsp_data !== 8'h00 || rsp_flags !== 4'h0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_out got d=%h f=%b busy=%b exp 00 0000 0", rsp_data, rsp_flags, busy); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1; if (rsp_valid !== 2'b00) seen = 1;
      @(negedge clk);
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL mid_rst_no_rsp got=1 exp=0"); end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    int g[$];
    int exp_g[6] = '{0, 0, 0, 0, 1, 0};
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11; req_lock = 2'b01;
    req_a = $urandom; req_b = $urandom; req_op = $urandom;
    for (int c = 0; c < 60 && g.size() < 6; c++) begin
      #1;
      if (req_ready !== 2'b00) g.push_back(onehot_idx(req_ready));
      @(negedge clk);
    end
    n_vec++;
    if (g.size() != 6) begin n_err++; $display("FAIL lock_count got=%0d exp=6", g.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++; if (g[i] != exp_g[i]) begin n_err++; $display("FAIL lock_grant%0d got=%0d exp=%0d", i, g[i], exp_g[i]); end
      end
    end
    req_valid = '0; req_lock = '0;
  endtask
`endif

  task automatic test_random();
    int pk;
    bit in_resp;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom_range(0, 3));
      req_a = NREQ*BITS'($urandom); req_b = NREQ*BITS'($urandom); req_op = NREQ*3'($urandom);
`ifdef ALU_ARB_LOCK_EN
      req_lock = ($urandom_range(0, 3) != 0) ? 2'b01 : NREQ'($urandom);
`endif
      #1;
      exp_rdy = '0; exp_rv = '0; pk = -1;
      if (!m_busy) begin
        pk = pick(req_valid, m_ptr);
        if (pk >= 0) exp_rdy[pk] = 1'b1;
      end
      in_resp = m_busy && (cyc - m_acc >= 2);
      if (in_resp) exp_rv[m_g] = 1'b1;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
      n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
      if (in_resp) begin
        n_vec++; if ({rsp_flags, rsp_data} !== m_exp) begin n_err++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, {rsp_flags, rsp_data}, m_exp); end
      end
      if (pk >= 0) begin
        m_busy = 1; m_g = pk; m_acc = cyc;
        m_exp = ref_alu(int'(req_a[pk*BITS +: BITS]), int'(req_b[pk*BITS +: BITS]), int'(req_op[pk*3 +: 3]));
        if (pk != m_ptr) m_lock = 0;
      end else if (in_resp && rsp_ready[m_g]) begin
        m_busy = 0;
`ifdef ALU_ARB_LOCK_EN
        if (req_lock[m_g] && m_lock < MAX_LOCK - 1) begin m_ptr = m_g; m_lock++; end
        else begin m_ptr = (m_g + 1) % NREQ; m_lock = 0; end
`else
        m_ptr = (m_g + 1) % NREQ;
`endif
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_or();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid_exec();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
